// File: rtl/register_file_mp_if.sv
// Bus bundle for register_file_mp: read ports, write ports, reservation,
// flush and the registered busy vector.
interface register_file_mp_if #(
  parameter int ARCH_LEN     = 32,
  parameter int REG_FILE_LEN = 32,
  parameter int NUM_RD       = 2,
  parameter int NUM_WR       = 1
);
  localparam int AW = $clog2(REG_FILE_LEN);

  logic [NUM_RD-1:0][AW-1:0]       rd_addr;
  logic [NUM_RD-1:0][ARCH_LEN-1:0] rd_data;
  logic [NUM_RD-1:0]               rd_busy;
  logic [NUM_WR-1:0]               wr_en;
  logic [NUM_WR-1:0][AW-1:0]       wr_addr;
  logic [NUM_WR-1:0][ARCH_LEN-1:0] wr_data;
  logic                            rsv_en;
  logic [AW-1:0]                   rsv_addr;
  logic                            flush;
  logic [REG_FILE_LEN-1:0]         busy_vec;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, flush,
    input  rd_data, rd_busy, busy_vec
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, flush,
    output rd_data, rd_busy, busy_vec
  );
endinterface

// File: rtl/register_file_mp.sv
// register_file_mp: multi-port integer register file with a per-register
// pending-write (busy) bit. Register 0 is hardwired to zero and never busy.
module register_file_mp #(
  parameter int ARCH_LEN     = 32,
  parameter int REG_FILE_LEN = 32,
  parameter int NUM_RD       = 2,
  parameter int NUM_WR       = 1,
  parameter int BYPASS       = 1
) (
  input logic               clk,
  input logic               rst,
  register_file_mp_if.slave bus
);
  localparam int AW = $clog2(REG_FILE_LEN);

  logic [ARCH_LEN-1:0]     regs [1:REG_FILE_LEN-1];
  logic [REG_FILE_LEN-1:0] busy;
  logic [REG_FILE_LEN-1:0] busy_nxt;

  // Next busy state: release on write, a new reservation overrides the release,
  // flush overrides everything; register 0 is forced idle.
  always_comb begin
    busy_nxt = busy;
    for (int p = 0; p < NUM_WR; p++) begin
      if (bus.wr_en[p]) busy_nxt[bus.wr_addr[p]] = 1'b0;
    end
    if (bus.rsv_en) busy_nxt[bus.rsv_addr] = 1'b1;
    if (bus.flush) busy_nxt = '0;
    busy_nxt[0] = 1'b0;
  end

  // Busy scoreboard register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy <= '0;
    else      busy <= busy_nxt;
  end

  // Data storage: later ports overwrite earlier ones, so the highest-indexed writer wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 1; r < REG_FILE_LEN; r++) regs[r] <= '0;
    end else begin
      for (int p = 0; p < NUM_WR; p++) begin
        if (bus.wr_en[p] && (bus.wr_addr[p] != '0)) regs[bus.wr_addr[p]] <= bus.wr_data[p];
      end
    end
  end

  // Combinational read ports, optionally forwarding same-cycle write data and busy release.
  always_comb begin
    bus.rd_data = '0;
    bus.rd_busy = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      logic [AW-1:0]       a;
      logic                hit;
      logic [ARCH_LEN-1:0] d;
      a   = bus.rd_addr[k];
      hit = 1'b0;
      d   = '0;
      if (a != '0) begin
        d = regs[a];
        if (BYPASS != 0) begin
          for (int p = 0; p < NUM_WR; p++) begin
            if (bus.wr_en[p] && (bus.wr_addr[p] == a)) begin
              hit = 1'b1;
              d   = bus.wr_data[p];
            end
          end
        end
      end
      bus.rd_data[k] = d;
      bus.rd_busy[k] = busy[a] && !hit;
    end
  end

  assign bus.busy_vec = busy;
endmodule

// File: doc/register_file_mp.md
# register_file_mp

Parametrised multi-port integer register file with a per-register pending-write scoreboard. It replaces the single-write, two-read register file in the decode/writeback path of the pipeline. Read-port and write-port counts are configurable, and write-to-read bypass is selectable. Each register carries a busy bit, which lets decode detect RAW hazards against in-flight producers without a separate scoreboard block.

## Interface
- ARCH_LEN, 32: data width of each register
- REG_FILE_LEN, 32: number of architectural registers (power of two ≥ 2); AW = $clog2(REG_FILE_LEN)
- NUM_RD, 2: number of read ports
- NUM_WR, 1: number of write ports (1–4)
- BYPASS, 1: 1 = same-cycle write data and busy release are visible on read ports; 0 = visible from next cycle

Ports:
- clk  in  1  clock; all state changes on posedge
- rst  in  1  asynchronous, active-low reset
- rd_addr  in  NUM_RD×AW  read addresses
- rd_data  out  NUM_RD×ARCH_LEN  read data (combinational)
- rd_busy  out  NUM_RD  busy bit of the addressed register (combinational)
- wr_en  in  NUM_WR  write-port valid
- wr_addr  in  NUM_WR×AW  write addresses
- wr_data  in  NUM_WR×ARCH_LEN  write data
- rsv_en  in  1  mark rsv_addr busy (issue of an instruction with a destination)
- rsv_addr  in  AW  register to reserve
- flush  in  1  clear all busy bits (pipeline flush)
- busy_vec  out  REG_FILE_LEN  registered busy bits; bit 0 is always 0

## Operation
- Register 0 is hardwired to zero: writes are ignored, reservations are ignored, reads return 0, and its busy bit stays 0 in every mode.
- Storage covers registers 1..REG_FILE_LEN-1. Every register, including the top index, is writable.
- Write: on posedge, for each port p with wr_en[p] and wr_addr[p] ≠ 0, reg[wr_addr[p]] ← wr_data[p].
- Multiple ports writing the same address in the same cycle: the highest-indexed port wins.
- Busy bit update per register r ≠ 0, in priority order (highest first):
  - flush → 0
  - rsv_en && rsv_addr == r → 1. A new reservation beats a release, so a new producer keeps the register pending.
  - any wr_en[p] && wr_addr[p] == r → 0
  - otherwise hold
- Read, BYPASS=1:
  - rd_data[k] = wr_data of the winning write port whose address matches rd_addr[k] this cycle; otherwise reg[rd_addr[k]].
  - rd_busy[k] = busy[rd_addr[k]] && no write port matches rd_addr[k] this cycle.
- Read, BYPASS=0: rd_data[k] = reg[rd_addr[k]]; rd_busy[k] = busy[rd_addr[k]].
- rd_busy never reflects a same-cycle rsv_en.
- Writing a register that is not busy is legal. The data is stored and the busy bit stays 0.

## Timing
- Reset (rst low, asynchronous): all registers = 0, all busy bits = 0, busy_vec = 0. rd_data and rd_busy follow combinationally, reading 0 (BYPASS=0).
- Reset deassertion: state is held until the first posedge with rst high.
- Reset asserted mid-operation: all state clears immediately regardless of wr_en, rsv_en or flush. Writes in that cycle are lost.
- Read latency: 0 cycles from address to data (combinational).
- Write-to-read visibility: same cycle with BYPASS=1; the following cycle with BYPASS=0.
- Reservation: busy_vec[r] goes to 1 on the posedge after rsv_en. rd_busy sees it from that cycle.
- Release: busy_vec[r] goes to 0 on the posedge after the write. With BYPASS=1, rd_busy drops in the write cycle itself.
- flush: busy_vec = 0 after the posedge. Writes in the same cycle still update data.
- There is no backpressure. All inputs are accepted every cycle.

## Test plan
- Reset/x0:
  - Assert rst low mid-run after writing reg5=0xDEADBEEF → rd_data for reg5 reads 0 immediately, busy_vec=0.
  - Write x0=0x1234 with rsv_en on x0 → x0 reads 0, busy_vec[0]=0.
- Top register and bypass (BYPASS=1):
  - Write reg31=0xA5A5A5A5 while rd_addr[0]=31 → rd_data[0]=0xA5A5A5A5 in the same cycle and the next cycle.
  - With BYPASS=0, the same stimulus reads the old value, then 0xA5A5A5A5 the next cycle.
- Write-port conflict (NUM_WR=2): both ports write reg7 (port0=0x11, port1=0x22) → reg7=0x22. The bypass read also returns 0x22.
- Scoreboard lifecycle:
  - rsv reg3 → busy_vec[3]=1 next cycle.
  - Write reg3=0x55 → with BYPASS=1, rd_busy=0 in the write cycle; busy_vec[3]=0 the next cycle.
  - rsv and write reg3 in the same cycle → busy_vec[3] stays 1, data=0x55.
- Flush: reserve reg2, reg9 and reg30, then assert flush together with rsv_en on reg4 → busy_vec=0 after the edge, including reg4.
- Random regression: random ports/addresses/enables over 10k cycles against a reference model → data and busy match every cycle.
